// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and defaults for the SPI transaction arbiter
package spi_arb_pkg;

    // Sequencer states: arbitrate, write strobe, timed wait, read strobe, completion pulse.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        XFER = 3'd2,
        READ = 3'd3,
        DONE = 3'd4
    } state_e;

    // Cycles from the end of the spi_master write strobe until the transfer completes.
    localparam int XFER_CYCLES_DEFAULT = 18;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
//
// Ports:
//   req    - per-requester request bits
//   ptr    - index searched first; search proceeds upward and wraps
//   grant  - one-hot winner (all zero when no request)
//   winner - binary index of the winner (zero when no request)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner
);

    int   idx;
    logic found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - shares one spi_master among NUM_REQ requesters
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   req         - level requests, held by each client until its done pulse
//   wdata       - packed write bytes, slice i belongs to req[i]
//   gnt         - one-hot current owner, held LOAD through DONE
//   done        - one-cycle completion pulse to the owner
//   rdata       - received byte, valid while any done bit is high
//   busy        - high whenever the sequencer is not IDLE
//   m_in_data, m_wr, m_rd, m_cs - drive spi_master (m_cs active low)
//   m_out_data  - received byte from spi_master
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int XFER_CYCLES = XFER_CYCLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           rdata,
    output logic                       busy,
    output logic [WIDTH-1:0]           m_in_data,
    output logic                       m_wr,
    output logic                       m_rd,
    output logic                       m_cs,
    input  logic [WIDTH-1:0]           m_out_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XFER_CYCLES - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     in_data_q, in_data_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]     arb_winner;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (ptr_q),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        in_data_d = in_data_q;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d = arb_grant;
                    cnt_d = CNT_LOAD;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_winner == PTR_W'(i)) begin
                            in_data_d = wdata[i*WIDTH +: WIDTH];
                        end
                    end
                    // Next search starts just past the winner so others get a turn.
                    if (arb_winner == PTR_W'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = arb_winner + 1'b1;
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = XFER;
            end
            XFER: begin
                // cnt enters at XFER_CYCLES-1, so XFER lasts exactly XFER_CYCLES cycles.
                if (cnt_q == '0) begin
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            READ: begin
                rdata_d = m_out_data;
                state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            in_data_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            in_data_q <= in_data_d;
            rdata_q   <= rdata_d;
        end
    end

    // Strobes decode straight from the state so reset clears them without a clock edge.
    assign m_wr      = (state_q == LOAD);
    assign m_rd      = (state_q == READ);
    assign m_cs      = !(m_wr || m_rd);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) ? gnt_q : '0;
    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign m_in_data = in_data_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int XC = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]   req;
    logic [NR*W-1:0] wdata;
    logic [NR-1:0]   gnt, done;
    logic [W-1:0]    rdata, m_in_data, m_out_data;
    logic            busy, m_wr, m_rd, m_cs;

    logic [1:0]  req2, gnt2, done2;
    logic [15:0] wdata2;
    logic [7:0]  rdata2, m_in_data2, m_out_data2;
    logic        busy2, m_wr2, m_rd2, m_cs2;

    spi_txn_arbiter #(.NUM_REQ(NR), .WIDTH(W), .XFER_CYCLES(XC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .busy(busy), .m_in_data(m_in_data), .m_wr(m_wr), .m_rd(m_rd),
        .m_cs(m_cs), .m_out_data(m_out_data)
    );

    spi_txn_arbiter #(.NUM_REQ(2), .WIDTH(8), .XFER_CYCLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .wdata(wdata2), .gnt(gnt2), .done(done2),
        .rdata(rdata2), .busy(busy2), .m_in_data(m_in_data2), .m_wr(m_wr2), .m_rd(m_rd2),
        .m_cs(m_cs2), .m_out_data(m_out_data2)
    );

    typedef struct {
        int   lo;
        int   hi;
        logic wr;
        logic rd;
        logic cs;
        logic dn;
    } phase_t;

    phase_t ph[4];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    function automatic logic [63:0] snap();
        return {44'd0, gnt, done, busy, m_wr, m_rd, m_cs, m_in_data};
    endfunction

    function automatic logic [63:0] snap2();
        return {48'd0, gnt2, done2, busy2, m_wr2, m_rd2, m_cs2, m_in_data2};
    endfunction

    task automatic check_idle(input string name);
        chk(name, {52'd0, gnt, done, busy, m_wr, m_rd, m_cs},
            {52'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic start(input logic [NR-1:0] r);
        req = r;
        cyc = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Walks one transaction whose LOAD cycle is load_cyc; drops req[owner] at offset drop_off.
    task automatic check_txn(input int load_cyc, input int owner, input logic [7:0] wb,
                             input logic [7:0] rb, input int drop_off);
        logic [3:0]  oh;
        logic [63:0] exp;
        oh = 4'b0001 << owner;
        for (int p = 0; p < 4; p++) begin
            for (int off = ph[p].lo; off <= ph[p].hi; off++) begin
                step_to(load_cyc + off);
                exp = {44'd0, oh, (ph[p].dn ? oh : 4'b0000), 1'b1,
                       ph[p].wr, ph[p].rd, ph[p].cs, wb};
                chk($sformatf("txn_l%0d_o%0d_off%0d", load_cyc, owner, off), snap(), exp);
                if (ph[p].dn) chk($sformatf("rdata_l%0d_o%0d", load_cyc, owner),
                                  {56'd0, rdata}, {56'd0, rb});
                if (off == drop_off) req[owner] = 1'b0;
            end
        end
    endtask

    initial begin
        ph[0] = '{0,      0,      1'b1, 1'b0, 1'b0, 1'b0};
        ph[1] = '{1,      XC,     1'b0, 1'b0, 1'b1, 1'b0};
        ph[2] = '{XC + 1, XC + 1, 1'b0, 1'b1, 1'b0, 1'b0};
        ph[3] = '{XC + 2, XC + 2, 1'b0, 1'b0, 1'b1, 1'b1};

        req = '0; wdata = '0; m_out_data = 8'h3C;
        req2 = '0; wdata2 = '0; m_out_data2 = 8'hC3;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", snap(), {44'd0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        chk("reset_rdata", {56'd0, rdata}, 64'd0);
        chk("reset_outs2", snap2(), {48'd0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        rst_n = 1'b1;

        // Basic write
        wdata[7:0] = 8'hAA;
        start(4'b0001);
        check_idle("basic_c0");
        check_txn(1, 0, 8'hAA, 8'h3C, XC + 2);
        step(); check_idle("basic_c22");
        step(); check_idle("basic_c23");

        // Full contention, order 0,1,2,3
        apply_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        start(4'b1111);
        for (int k = 0; k < 4; k++) begin
            check_txn(1 + 22 * k, k, wdata[k*8 +: 8], 8'h3C, XC + 2);
        end
        step(); check_idle("cont_end");

        // Fairness: req0 and req2 held throughout
        apply_reset();
        m_out_data = 8'h5A;
        wdata = {8'hF3, 8'hC2, 8'hF1, 8'hC0};
        start(4'b0101);
        check_txn(1,  0, 8'hC0, 8'h5A, -1);
        check_txn(23, 2, 8'hC2, 8'h5A, -1);
        check_txn(45, 0, 8'hC0, 8'h5A, -1);
        check_txn(67, 2, 8'hC2, 8'h5A, XC + 2);
        req = '0;
        step(); check_idle("fair_end");

        // Request dropped mid-transfer still completes
        apply_reset();
        m_out_data = 8'h96;
        wdata[15:8] = 8'hB1;
        start(4'b0010);
        check_txn(1, 1, 8'hB1, 8'h96, 5);
        step(); check_idle("drop_c22");
        step(); check_idle("drop_c23");

        // Reset in the middle of a transfer
        wdata[23:16] = 8'h77;
        start(4'b0100);
        step_to(10);
        chk("prerst_gnt", {60'd0, gnt}, {60'd0, 4'b0100});
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", snap(), {44'd0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        chk("rst_async_rdata", {56'd0, rdata}, 64'd0);
        req = '0;
        repeat (2) step();
        check_idle("rst_hold");
        rst_n = 1'b1;
        wdata[31:24] = 8'hD3;
        m_out_data = 8'h4E;
        start(4'b1000);
        check_txn(1, 3, 8'hD3, 8'h4E, XC + 2);
        step(); check_idle("rst_req3_end");

        // Pointer restarts at 0 after a mid-transfer reset
        wdata[15:8] = 8'hB1;
        start(4'b0010);
        step_to(10);
        rst_n = 1'b0;
        #1;
        req = '0;
        step();
        rst_n = 1'b1;
        start(4'b1010);
        check_txn(1,  1, 8'hB1, 8'h4E, XC + 2);
        check_txn(23, 3, 8'hD3, 8'h4E, XC + 2);
        step(); check_idle("ptr_rst_end");

        // Edge parameters: NUM_REQ=2, XFER_CYCLES=1
        wdata2[15:8] = 8'h5A;
        req2 = 2'b10;
        step(); chk("e_load", snap2(), {48'd0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
        step(); chk("e_xfer", snap2(), {48'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A});
        step(); chk("e_read", snap2(), {48'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A});
        step(); chk("e_done", snap2(), {48'd0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A});
        chk("e_rdata", {56'd0, rdata2}, {56'd0, 8'hC3});
        req2 = 2'b00;
        step(); chk("e_idle", snap2(), {48'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A});
        // Pointer wrapped to 0, so with both requesting, 0 wins then 1
        wdata2[7:0] = 8'h6B;
        m_out_data2 = 8'h2D;
        req2 = 2'b11;
        step(); chk("e2_load0", snap2(), {48'd0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h6B});
        repeat (3) step();
        chk("e2_done0", snap2(), {48'd0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h6B});
        chk("e2_rdata0", {56'd0, rdata2}, {56'd0, 8'h2D});
        req2[0] = 1'b0;
        step(); chk("e2_idle", {62'd0, gnt2}, 64'd0);
        step(); chk("e2_load1", snap2(), {48'd0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
        req2 = 2'b00;
        repeat (4) step();
        chk("e2_final", snap2(), {48'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one spi_master (8-bit, wr/rd/cs strobes, fixed-length transfer, no busy output) among NUM_REQ requesters.
- Round-robin arbitration picks a requester, then sequences the master: load-and-write strobe, timed transfer wait, read strobe, result capture.
- Returns the received byte and a one-cycle done pulse to the winner.
- Sits between client logic and spi_master; spi_master is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width; must match spi_master
- XFER_CYCLES, 18, clk cycles from end of wr strobe to transfer complete (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester level request, held until done
- wdata  in  NUM_REQ*WIDTH  packed write bytes; slice i belongs to req[i]
- gnt  out  NUM_REQ  one-hot, current owner
- done  out  NUM_REQ  one-cycle completion pulse to owner
- rdata  out  WIDTH  received byte; valid while any done bit is high
- busy  out  1  high whenever state != IDLE
- m_in_data  out  WIDTH  to spi_master in_data
- m_wr  out  1  to spi_master wr
- m_rd  out  1  to spi_master rd
- m_cs  out  1  to spi_master cs, active low
- m_out_data  in  WIDTH  from spi_master out_data

Behaviour:
- Reset values: state IDLE, gnt=0, done=0, rdata=0, busy=0, m_in_data=0, m_wr=0, m_rd=0, m_cs=1, cnt=0, rr pointer=0.
- Reset asserted at any time, including mid-transfer, forces these values immediately. No transfer resumes after reset.
- FSM states: IDLE, LOAD, XFER, READ, DONE.
- Cycle 0, IDLE with any req bit high:
  - winner = first set bit searching from pointer upward, wrapping at NUM_REQ.
  - Register gnt, m_in_data <= wdata slice, cnt <= XFER_CYCLES-1.
  - Go to LOAD. Pointer <= winner+1, mod NUM_REQ.
- Cycle 1, LOAD: m_wr=1, m_cs=0 for exactly one cycle. Go to XFER.
- Cycles 2..XFER_CYCLES+1, XFER: m_wr=0, m_cs=1. cnt decrements each cycle. Leave for READ when cnt==0.
- Cycle XFER_CYCLES+2, READ: m_rd=1, m_cs=0 for one cycle. rdata <= m_out_data at the end of this cycle.
- Cycle XFER_CYCLES+3, DONE: done[winner]=1. Next state IDLE.
- gnt is held from LOAD through DONE and cleared on the IDLE entry edge.
- m_in_data is held stable from LOAD through DONE.
- Minimum spacing between successive LOAD cycles: XFER_CYCLES+4 cycles. No arbitration happens outside IDLE.
- req changes after cycle 0 are ignored. A dropped req still completes, and done still pulses.
- Clients must drop req on the edge after done, or they re-enter arbitration. Round-robin still rotates to others.
- Simultaneous requests: exactly one gnt bit. With all req held, grant order is 0,1,…,NUM_REQ-1,0,…
- cnt width: $clog2(XFER_CYCLES+1). No arithmetic overflow is possible.
- m_wr and m_rd are never high in the same cycle.
- m_cs is low only during LOAD and READ.

Decomposition:
- Package spi_arb_pkg: state enum (IDLE, LOAD, XFER, READ, DONE) and default XFER_CYCLES constant.
- One sub-module rr_arbiter: combinational NUM_REQ-bit round-robin picker. Inputs req and pointer; outputs one-hot grant and winner index.
- FSM, counter and pointer register live in spi_txn_arbiter.

Test Plan:
- Basic write (XFER_CYCLES=18, stub m_out_data=8'h3C): req[0] with wdata[0]=8'hAA →
  - m_in_data=8'hAA, m_wr=1/m_cs=0 at cycle 1 only.
  - m_rd=1/m_cs=0 at cycle 20.
  - done[0] at cycle 21 with rdata=8'h3C; busy low at cycle 22.
- Full contention: all four req high with bytes 8'h11/22/33/44 →
  - LOAD cycles at 1, 23, 45, 67.
  - gnt order 0,1,2,3; m_in_data matches each owner; each done pulses once.
- Fairness: req[0] and req[2] held continuously → grant sequence 0,2,0,2. req[1] and req[3] never granted.
- Request drop: req[1] deasserted during XFER → transfer completes, done[1] pulses at cycle 21, next IDLE grants nothing.
- Reset mid-op: rst_n low at cycle 10 of a transfer →
  - Immediately gnt=0, m_cs=1, m_wr=m_rd=0, busy=0, no done.
  - After release, req[3] alone is granted: pointer restarted at 0, full sequence correct.
- Edge parameter: XFER_CYCLES=1, NUM_REQ=2 → LOAD cycle 1, XFER cycle 2, READ cycle 3, done cycle 4.
